wb_regfile_hilo: RTL
====================

Name: wb_regfile_hilo

Overview:
- Write-back consumer at the far end of the MEM/WB pipeline register.
- Accepts the registered WB-stage writes (GPR address/enable/data, HI/LO data/enable) and commits them to the architectural state: a 32x32 GPR file and the HI/LO pair.
- Serves two combinational GPR read ports to ID and exposes HI/LO to EX.
- Counts committed write-back events for debug.

Parameters:
- DATA_W, 32, GPR/HI/LO data width (matches RegBus).
- ADDR_W, 5, GPR address width (matches RegAddrBus).
- NUM_REGS, 32, number of GPRs; r0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- wb_waddr_reg_i  in  ADDR_W  GPR write address from the WB stage.
- wb_we_reg_i  in  1  GPR write enable from the WB stage.
- wb_wdata_i  in  DATA_W  GPR write data.
- wb_hi_i  in  DATA_W  HI write data.
- wb_lo_i  in  DATA_W  LO write data.
- wb_whilo_i  in  1  HI/LO write enable.
- re1_i  in  1  read port 1 enable.
- raddr1_i  in  ADDR_W  read port 1 address.
- rdata1_o  out  DATA_W  read port 1 data, combinational.
- re2_i  in  1  read port 2 enable.
- raddr2_i  in  ADDR_W  read port 2 address.
- rdata2_o  out  DATA_W  read port 2 data, combinational.
- hi_o  out  DATA_W  current HI value.
- lo_o  out  DATA_W  current LO value.
- wb_commit_cnt_o  out  32  committed write-back event count.

Behaviour:
- Reset (rst=1 at posedge):
  - GPRs r1..r31, HI, LO and the commit counter are cleared to 0.
  - rst has priority over a same-cycle write; that write is dropped.
  - While rst=1, rdata1_o, rdata2_o, hi_o and lo_o read 0 combinationally.
- GPR write: at posedge, if wb_we_reg_i=1 and wb_waddr_reg_i!=0, regs[waddr] <= wb_wdata_i. A write to r0 is silently discarded.
- HI/LO write: at posedge, if wb_whilo_i=1, HI <= wb_hi_i and LO <= wb_lo_i together. There is no partial update.
- GPR write and HI/LO write in the same cycle are independent; both commit.
- Read port n, priority order:
  1. rst=1 -> 0.
  2. ren=0 -> 0.
  3. raddrn=0 -> 0.
  4. Bypass hit (see Optional Feature) -> wb_wdata_i.
  5. Otherwise -> regs[raddrn].
- Both ports may read the same address; both return the same value.
- Write latency: one cycle. Without bypass, a read in the cycle after the write edge returns the new value.
- Commit counter:
  - Increments by exactly 1 at posedge when (wb_we_reg_i & waddr!=0) | wb_whilo_i.
  - A simultaneous GPR and HI/LO write counts once.
  - Wraps 0xFFFF_FFFF -> 0.
  - Holds otherwise.
- No stall input. The upstream stage delivers NOP bubbles (we=0, whilo=0) when stalled; the block commits exactly what it sees each cycle.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - GPR read port n returns wb_wdata_i when wb_we_reg_i=1, wb_waddr_reg_i==raddrn, raddrn!=0 and ren=1 (same-cycle write-through).
  - hi_o/lo_o return wb_hi_i/wb_lo_i when wb_whilo_i=1.
  - rst still forces all read outputs to 0.
- Undefined:
  - Reads always return array/HI/LO contents.
  - A same-cycle write becomes visible one cycle later; ID must forward from WB itself.

Decomposition:
- Shared header constants: RegBus, RegAddrBus, RegNum (32), RstEnable, WriteEnable, ReadEnable, ZeroWord, NOPRegAddr. Add RegNum if not already present.
- Natural sub-module: hilo_reg. It holds HI/LO with the whilo write, reset and optional bypass.
- The GPR array, read muxes and commit counter stay in the top module.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then re1=1 raddr1=5 -> rdata1_o=0, hi_o=lo_o=0, wb_commit_cnt_o=0.
- Write/read-back: we=1 waddr=3 wdata=0xDEADBEEF, next cycle re1=1 raddr1=3 -> rdata1_o=0xDEADBEEF; re2=0 -> rdata2_o=0; counter=1.
- r0 protection: we=1 waddr=0 wdata=0x12345678, then read raddr1=0 -> 0; counter unchanged.
- Same-cycle read of the written address: we=1 waddr=7 wdata=0xA5A5A5A5 with re1=1 raddr1=7, old r7=0x11:
  - with WB_BYPASS_EN -> rdata1_o=0xA5A5A5A5 that cycle.
  - without it -> 0x11 that cycle and 0xA5A5A5A5 the next.
- HI/LO plus GPR together: whilo=1 hi=0x1 lo=0x2 and we=1 waddr=9 in one cycle -> next cycle hi_o=0x1, lo_o=0x2, r9 updated, counter +1 (not +2).
- Reset priority and wrap:
  - rst=1 with we=1 waddr=4 -> r4 stays 0.
  - Force counter to 0xFFFFFFFF via 2^32-1 commits (or a backdoor preload), one more commit -> wb_commit_cnt_o=0.

Source files
------------

// File: rtl/wb_regfile_hilo_pkg.sv
// Shared constants for the write-back register file slice.
// Bus widths, enable polarities and the canonical zero values.
package wb_regfile_hilo_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/wb_regfile_hilo_if.sv
// WB-stage writes, ID read ports and EX HI/LO view, bundled as one interface.
// The master modport is the pipeline side; the slave modport is the register file.
interface wb_regfile_hilo_if
  import wb_regfile_hilo_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
);
  logic [ADDR_W-1:0] wb_waddr_reg_i;
  logic              wb_we_reg_i;
  logic [DATA_W-1:0] wb_wdata_i;
  logic [DATA_W-1:0] wb_hi_i;
  logic [DATA_W-1:0] wb_lo_i;
  logic              wb_whilo_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [31:0]       wb_commit_cnt_o;

  modport master (
    output wb_waddr_reg_i, wb_we_reg_i, wb_wdata_i, wb_hi_i, wb_lo_i, wb_whilo_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, hi_o, lo_o, wb_commit_cnt_o
  );

  modport slave (
    input  wb_waddr_reg_i, wb_we_reg_i, wb_wdata_i, wb_hi_i, wb_lo_i, wb_whilo_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o, hi_o, lo_o, wb_commit_cnt_o
  );
endinterface

// File: rtl/wb_regfile_hilo_hilo_reg.sv
// HI/LO pair, written together on whilo; outputs forced to zero while in reset.
// WB_BYPASS_EN: when defined, a same-cycle HI/LO write is visible on hi/lo immediately.
module hilo_reg
  import wb_regfile_hilo_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (whilo == WriteEnable) begin
      hi_q <= hi_in;
      lo_q <= lo_in;
    end
  end

  always_comb begin
    hi = hi_q;
    lo = lo_q;
`ifdef WB_BYPASS_EN
    if (whilo == WriteEnable) begin
      hi = hi_in;
      lo = lo_in;
    end
`endif
    if (rst == RstEnable) begin
      hi = '0;
      lo = '0;
    end
  end

endmodule

// File: rtl/wb_regfile_hilo.sv
// Write-back consumer: 32x32 GPR file with two read ports, HI/LO pair and commit counter.
// WB_BYPASS_EN: when defined, reads of the address being written return the write data.
module wb_regfile_hilo
  import wb_regfile_hilo_pkg::*;
#(
  parameter int DATA_W   = RegBus,
  parameter int ADDR_W   = RegAddrBus,
  parameter int NUM_REGS = RegNum
) (
  input logic              clk,
  input logic              rst,
  wb_regfile_hilo_if.slave bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [31:0]       commit_cnt;
  logic              gpr_commit;
  logic              commit;

  // r0 is never written, so it stays at its reset value of zero
  assign gpr_commit = (bus.wb_we_reg_i == WriteEnable) && (bus.wb_waddr_reg_i != NOPRegAddr);
  assign commit     = gpr_commit || (bus.wb_whilo_i == WriteEnable);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (gpr_commit) begin
      regs[bus.wb_waddr_reg_i] <= bus.wb_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) commit_cnt <= ZeroWord;
    else if (commit)      commit_cnt <= commit_cnt + 32'd1;
  end

  assign bus.wb_commit_cnt_o = commit_cnt;

  function automatic logic [DATA_W-1:0] gpr_read(input logic re, input logic [ADDR_W-1:0] addr);
    if (rst == RstEnable)      return '0;
    if (re != ReadEnable)      return '0;
    if (addr == NOPRegAddr)    return '0;
`ifdef WB_BYPASS_EN
    if (bus.wb_we_reg_i == WriteEnable && bus.wb_waddr_reg_i == addr) return bus.wb_wdata_i;
`endif
    return regs[addr];
  endfunction

  always_comb begin
    bus.rdata1_o = gpr_read(bus.re1_i, bus.raddr1_i);
    bus.rdata2_o = gpr_read(bus.re2_i, bus.raddr2_i);
  end

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk   (clk),
    .rst   (rst),
    .whilo (bus.wb_whilo_i),
    .hi_in (bus.wb_hi_i),
    .lo_in (bus.wb_lo_i),
    .hi    (bus.hi_o),
    .lo    (bus.lo_o)
  );

endmodule
